// File: rtl/pokey_poly_ctrl_if.sv
// Bundle of signals between the poly sequencer, the CPU-side register
// decode, the poly generator and the audio channels.
//   master : register decode / generator / channels side (drives requests,
//            poly bits and strobes; receives init, sel9, read data, noise)
//   slave  : pokey_poly_ctrl
interface pokey_poly_ctrl_if;
    logic       skctl_init;
    logic       audctl_poly9;
    logic       poly_out;
    logic [7:0] poly_rand;
    logic       poly_init_L;
    logic       poly_sel9;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] ch_sample;
    logic [3:0] ch_noise;
    logic       busy;

    modport master (
        output skctl_init, audctl_poly9, poly_out, poly_rand, rd_req, ch_sample,
        input  poly_init_L, poly_sel9, rd_data, rd_valid, ch_noise, busy
    );

    modport slave (
        input  skctl_init, audctl_poly9, poly_out, poly_rand, rd_req, ch_sample,
        output poly_init_L, poly_sel9, rd_data, rd_valid, ch_noise, busy
    );
endinterface

// File: rtl/pokey_poly_ctrl.sv
// Sequencer and access controller for the POKEY 17/9-bit poly noise generator.
// Drives the generator init/mode-select, stretches init to a minimum pulse on
// every mode change, serves RANDOM reads and latches the serial poly bit into
// the four audio channels on their sample strobes.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   pif (slave)  : skctl_init, audctl_poly9, poly_out, poly_rand, rd_req,
//                  ch_sample in; poly_init_L, poly_sel9, rd_data, rd_valid,
//                  ch_noise, busy out (all outputs registered)
//
// state | meaning
// PULSE | minimum-length init pulse after reset / mode change
// HOLD  | SKCTL holds the poly in init
// RUN   | poly generator free-running
module pokey_poly_ctrl #(
    parameter int unsigned INIT_CYCLES     = 4,
    parameter logic [7:0]  RANDOM_INIT_VAL = 8'hFF
) (
    input logic              clk,
    input logic              reset,
    pokey_poly_ctrl_if.slave pif
);

    typedef enum logic [1:0] {
        PULSE = 2'd0,
        HOLD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(INIT_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] cnt_dec;

    assign cnt_dec = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= PULSE;
            cnt             <= CNT_LOAD;
            pif.poly_init_L <= 1'b0;
            pif.poly_sel9   <= 1'b0;
            pif.busy        <= 1'b1;
            pif.rd_data     <= 8'h00;
            pif.rd_valid    <= 1'b0;
            pif.ch_noise    <= 4'b0000;
        end else begin
            case (state)
                RUN: begin
                    if (pif.skctl_init) begin
                        state           <= HOLD;
                        cnt             <= CNT_LOAD;
                        pif.poly_init_L <= 1'b0;
                        pif.busy        <= 1'b1;
                    end else if (pif.audctl_poly9 != pif.poly_sel9) begin
                        // sel9 moves on the same edge init drops, so the
                        // generator only sees the new mode while in init
                        state           <= PULSE;
                        cnt             <= CNT_LOAD;
                        pif.poly_sel9   <= pif.audctl_poly9;
                        pif.poly_init_L <= 1'b0;
                        pif.busy        <= 1'b1;
                    end
                end
                PULSE: begin
                    pif.poly_sel9 <= pif.audctl_poly9;
                    if (pif.skctl_init) begin
                        state <= HOLD;
                        cnt   <= cnt_dec;
                    end else if (cnt == 4'd0) begin
                        state           <= RUN;
                        pif.poly_init_L <= 1'b1;
                        pif.busy        <= 1'b0;
                    end else begin
                        cnt <= cnt_dec;
                    end
                end
                HOLD: begin
                    pif.poly_sel9 <= pif.audctl_poly9;
                    if (!pif.skctl_init && cnt == 4'd0) begin
                        state           <= RUN;
                        pif.poly_init_L <= 1'b1;
                        pif.busy        <= 1'b0;
                    end else if (!pif.skctl_init) begin
                        // pulse not yet long enough: finish it in PULSE
                        state <= PULSE;
                        cnt   <= cnt_dec;
                    end else begin
                        cnt <= cnt_dec;
                    end
                end
                default: begin
                    state           <= PULSE;
                    cnt             <= CNT_LOAD;
                    pif.poly_init_L <= 1'b0;
                    pif.busy        <= 1'b1;
                end
            endcase

            pif.rd_valid <= pif.rd_req;
            if (pif.rd_req)
                pif.rd_data <= (state == RUN) ? pif.poly_rand : RANDOM_INIT_VAL;

            for (int i = 0; i < 4; i++) begin
                if (pif.ch_sample[i])
                    pif.ch_noise[i] <= (state == RUN) ? pif.poly_out : 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pokey_poly_ctrl.sv
module tb_pokey_poly_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    pokey_poly_ctrl_if pif ();

    pokey_poly_ctrl #(
        .INIT_CYCLES     (4),
        .RANDOM_INIT_VAL (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pif   (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // one clock edge, then settle away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // called just after the edge that started an init pulse
    task automatic expect_pulse(input string tag, input logic sel);
        chk({tag, "_lo0"}, pif.poly_init_L, 1'b0);
        chk({tag, "_busy0"}, pif.busy, 1'b1);
        chk({tag, "_sel"}, pif.poly_sel9, sel);
        for (int i = 1; i < 4; i++) begin
            step();
            chk({tag, "_lo"}, pif.poly_init_L, 1'b0);
        end
        step();
        chk({tag, "_hi"}, pif.poly_init_L, 1'b1);
        chk({tag, "_busy_done"}, pif.busy, 1'b0);
        chk({tag, "_sel_done"}, pif.poly_sel9, sel);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset              = 1'b1;
        pif.skctl_init     = 1'b0;
        pif.audctl_poly9   = 1'b0;
        pif.poly_out       = 1'b0;
        pif.poly_rand      = 8'h00;
        pif.rd_req         = 1'b0;
        pif.ch_sample      = 4'b0000;
        step();
        step();
        chk("rst_rd_data", pif.rd_data, 8'h00);
        chk("rst_rd_valid", pif.rd_valid, 1'b0);
        chk("rst_ch_noise", pif.ch_noise, 4'b0000);
        reset = 1'b0;
        expect_pulse("rst", 1'b0);

        // mode change 17 -> 9 -> 17
        pif.audctl_poly9 = 1'b1;
        step();
        expect_pulse("mode9", 1'b1);
        pif.audctl_poly9 = 1'b0;
        step();
        expect_pulse("mode17", 1'b0);

        // single read in RUN, data holds afterwards
        pif.poly_rand = 8'hA5;
        pif.rd_req    = 1'b1;
        step();
        pif.rd_req    = 1'b0;
        chk("rd_valid", pif.rd_valid, 1'b1);
        chk("rd_data", pif.rd_data, 8'hA5);
        pif.poly_rand = 8'h11;
        step();
        chk("rd_valid_drop", pif.rd_valid, 1'b0);
        chk("rd_data_hold", pif.rd_data, 8'hA5);

        // back-to-back reads
        pif.rd_req    = 1'b1;
        pif.poly_rand = 8'hA5;
        step();
        chk("burst0_v", pif.rd_valid, 1'b1);
        chk("burst0_d", pif.rd_data, 8'hA5);
        pif.poly_rand = 8'h3C;
        step();
        chk("burst1_v", pif.rd_valid, 1'b1);
        chk("burst1_d", pif.rd_data, 8'h3C);
        pif.poly_rand = 8'h77;
        step();
        chk("burst2_v", pif.rd_valid, 1'b1);
        chk("burst2_d", pif.rd_data, 8'h77);
        pif.rd_req = 1'b0;
        step();
        chk("burst_end_v", pif.rd_valid, 1'b0);

        // noise latching in RUN
        pif.poly_out  = 1'b1;
        pif.ch_sample = 4'b1111;
        step();
        chk("noise_all1", pif.ch_noise, 4'b1111);
        pif.poly_out  = 1'b0;
        pif.ch_sample = 4'b1010;
        step();
        chk("noise_1010", pif.ch_noise, 4'b0101);
        pif.ch_sample = 4'b0001;
        step();
        chk("noise_ch0", pif.ch_noise, 4'b0100);
        pif.ch_sample = 4'b0000;
        pif.poly_out  = 1'b1;
        step();
        chk("noise_hold", pif.ch_noise, 4'b0100);

        // HOLD: noise forced to 1, RANDOM returns init value
        pif.poly_out   = 1'b0;
        pif.skctl_init = 1'b1;
        step();
        chk("hold_init_L", pif.poly_init_L, 1'b0);
        chk("hold_busy", pif.busy, 1'b1);
        pif.ch_sample = 4'b0001;
        step();
        pif.ch_sample = 4'b0000;
        chk("hold_noise", pif.ch_noise, 4'b0101);
        pif.poly_rand = 8'h12;
        pif.rd_req    = 1'b1;
        step();
        pif.rd_req    = 1'b0;
        chk("hold_rd_v", pif.rd_valid, 1'b1);
        chk("hold_rd_d", pif.rd_data, 8'hFF);
        pif.skctl_init = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (pif.poly_init_L !== 1'b1 && cyc < 10) begin
                step();
                cyc++;
            end
            chk("hold_release_run", pif.poly_init_L, 1'b1);
        end

        // one-cycle skctl_init in RUN still yields a full-length pulse
        pif.skctl_init = 1'b1;
        step();
        pif.skctl_init = 1'b0;
        expect_pulse("skpulse", 1'b0);

        // skctl_init two cycles into a PULSE, held 10 cycles
        pif.audctl_poly9 = 1'b1;
        step();
        step();
        pif.skctl_init = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("longhold_lo", pif.poly_init_L, 1'b0);
        end
        pif.skctl_init = 1'b0;
        step();
        chk("longhold_run", pif.poly_init_L, 1'b1);
        chk("longhold_sel", pif.poly_sel9, 1'b1);
        chk("longhold_busy", pif.busy, 1'b0);

        // reset mid-operation with a read and a mode change pending
        pif.audctl_poly9 = 1'b0;
        pif.rd_req       = 1'b1;
        pif.poly_rand    = 8'h5A;
        reset            = 1'b1;
        step();
        chk("mrst_rd_valid", pif.rd_valid, 1'b0);
        chk("mrst_rd_data", pif.rd_data, 8'h00);
        chk("mrst_ch_noise", pif.ch_noise, 4'b0000);
        pif.rd_req = 1'b0;
        reset      = 1'b0;
        expect_pulse("mrst", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
